// File: rtl/background_tile_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : background_tile_fetch                                           |
// | Resolves a background block address and pixel coordinate into a pixel   |
// | colour via the map RAM (tile index) and the tile sprite RAM (colour).    |
// | Fixed 4-edge latency, one pixel per clock, no stall.                     |
// | Optional feature macro: BG_TILE_REUSE_EN (skip map reads for repeated    |
// | block addresses within a run of active pixels).                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module background_tile_fetch #(
  parameter int SIZE_X       = 10,
  parameter int SIZE_Y       = 10,
  parameter int SIZE_ADDRESS = 13,
  parameter int TILE_BITS    = 6,
  parameter int COLOR_BITS   = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_video_on,
  input  logic [SIZE_X-1:0]       i_pixel_x,
  input  logic [SIZE_Y-1:0]       i_pixel_y,
  input  logic [SIZE_ADDRESS-1:0] i_addr_block,
  output logic                    o_map_rd_en,
  output logic [SIZE_ADDRESS-1:0] o_map_addr,
  input  logic [TILE_BITS-1:0]    i_map_data,
  output logic                    o_sprite_rd_en,
  output logic [TILE_BITS+5:0]    o_sprite_addr,
  input  logic [COLOR_BITS-1:0]   i_sprite_data,
  output logic [COLOR_BITS-1:0]   o_bg_color,
  output logic                    o_bg_valid
);

  // Stage registers
  logic                    r_map_rd_en;
  logic [SIZE_ADDRESS-1:0] r_map_addr;
  logic                    r_v1, r_v2, r_v3, r_v4;
  logic [5:0]              r_off1, r_off2;
  logic                    r_sprite_rd_en;
  logic [TILE_BITS+5:0]    r_sprite_addr;
  logic [COLOR_BITS-1:0]   r_bg_color;
  logic                    r_bg_valid;

  logic                    w_map_rd;
  logic [TILE_BITS-1:0]    w_tile;

  // Only the in-block offset bits of the coordinates are needed here.
  logic w_unused_coord_bits;
  assign w_unused_coord_bits = ^{i_pixel_x[SIZE_X-1:3], i_pixel_y[SIZE_Y-1:3]};

`ifdef BG_TILE_REUSE_EN
  logic [SIZE_ADDRESS-1:0] r_last_addr;
  logic                    r_last_ok;
  logic                    r_rd2;
  logic [TILE_BITS-1:0]    r_held_tile;

  // A repeated block address inside an unbroken active run reuses the held tile.
  assign w_map_rd = i_video_on & ~(r_last_ok & (i_addr_block == r_last_addr));
  assign w_tile   = r_rd2 ? i_map_data : r_held_tile;

  // Track the last requested block and the tile returned for the last real read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_addr <= '0;
      r_last_ok   <= 1'b0;
      r_rd2       <= 1'b0;
      r_held_tile <= '0;
    end else begin
      r_last_ok <= i_video_on;
      if (i_video_on) r_last_addr <= i_addr_block;
      r_rd2 <= r_map_rd_en;
      if (r_rd2) r_held_tile <= i_map_data;
    end
  end
`else
  assign w_map_rd = i_video_on;
  assign w_tile   = i_map_data;
`endif

  // Stage 1: launch the map read and capture the in-block pixel offset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_map_rd_en <= 1'b0;
      r_map_addr  <= '0;
      r_v1        <= 1'b0;
      r_off1      <= '0;
    end else begin
      r_map_rd_en <= w_map_rd;
      r_v1        <= i_video_on;
      r_off1      <= {i_pixel_y[2:0], i_pixel_x[2:0]};
      if (i_video_on) r_map_addr <= i_addr_block;
    end
  end

  // Stage 2: wait for the map RAM; carry offset and validity along.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v2   <= 1'b0;
      r_off2 <= '0;
    end else begin
      r_v2   <= r_v1;
      r_off2 <= r_off1;
    end
  end

  // Stage 3: form the sprite address {tile, oy, ox} and launch the sprite read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sprite_rd_en <= 1'b0;
      r_sprite_addr  <= '0;
      r_v3           <= 1'b0;
    end else begin
      r_sprite_rd_en <= r_v2;
      r_v3           <= r_v2;
      if (r_v2) r_sprite_addr <= {w_tile, r_off2};
    end
  end

  // Stages 4 and 5: wait for the sprite RAM, then register the gated colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v4       <= 1'b0;
      r_bg_color <= '0;
      r_bg_valid <= 1'b0;
    end else begin
      r_v4       <= r_v3;
      r_bg_color <= r_v4 ? i_sprite_data : '0;
      r_bg_valid <= r_v4;
    end
  end

  assign o_map_rd_en    = r_map_rd_en;
  assign o_map_addr     = r_map_addr;
  assign o_sprite_rd_en = r_sprite_rd_en;
  assign o_sprite_addr  = r_sprite_addr;
  assign o_bg_color     = r_bg_color;
  assign o_bg_valid     = r_bg_valid;

endmodule
`default_nettype wire

// File: tb/tb_background_tile_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_background_tile_fetch                                        |
// | Self-checking bench for background_tile_fetch with model map and sprite  |
// | RAMs and a reference pixel model.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_background_tile_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic [12:0] addr = '0;
  logic        map_rd_en, sprite_rd_en, bg_valid;
  logic [12:0] map_addr;
  logic [11:0] sprite_addr;
  logic [5:0]  map_q = '0;
  logic [8:0]  spr_q = '0;
  logic [8:0]  bg_color;

  logic [5:0]  map_mem    [0:8191];
  logic [8:0]  sprite_mem [0:4095];

  int checks = 0;
  int failures = 0;
  int map_pulses = 0;
  int spr_pulses = 0;

  // Expected outputs, one entry per sampling edge, consumed 4 edges later.
  logic       ev_q [$];
  logic [8:0] ec_q [$];

  background_tile_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .i_video_on     (video_on),
    .i_pixel_x      (px),
    .i_pixel_y      (py),
    .i_addr_block   (addr),
    .o_map_rd_en    (map_rd_en),
    .o_map_addr     (map_addr),
    .i_map_data     (map_q),
    .o_sprite_rd_en (sprite_rd_en),
    .o_sprite_addr  (sprite_addr),
    .i_sprite_data  (spr_q),
    .o_bg_color     (bg_color),
    .o_bg_valid     (bg_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM models and strobe counters.
  always @(posedge clk) begin
    if (map_rd_en)    map_q <= map_mem[map_addr];
    if (sprite_rd_en) spr_q <= sprite_mem[sprite_addr];
    if (map_rd_en)    map_pulses <= map_pulses + 1;
    if (sprite_rd_en) spr_pulses <= spr_pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: colour = sprite word tile*64 + (y mod 8)*8 + (x mod 8).
  function automatic logic [8:0] ref_color(input int a, input int x, input int y);
    int idx;
    idx = int'(map_mem[a]) * 64 + (y % 8) * 8 + (x % 8);
    return sprite_mem[idx];
  endfunction

  function automatic int blk(input int x, input int y);
    return (y / 8) * 80 + (x / 8);
  endfunction

  task automatic prime();
    ev_q.delete();
    ec_q.delete();
    repeat (4) begin
      ev_q.push_back(1'b0);
      ec_q.push_back('0);
    end
  endtask

  // Drive one pixel from a falling edge; return the expectation for the output now visible.
  task automatic step(input logic v, input int x, input int y, input int a,
                      output logic ev, output logic [8:0] ec);
    video_on = v;
    px       = 10'(x);
    py       = 10'(y);
    addr     = 13'(a);
    ev_q.push_back(v);
    ec_q.push_back(v ? ref_color(a, x, y) : 9'd0);
    @(posedge clk);
    @(negedge clk);
    ev = ev_q.pop_front();
    ec = ec_q.pop_front();
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({map_rd_en, map_addr, sprite_rd_en, sprite_addr, bg_color, bg_valid} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {map_rd_en, map_addr, sprite_rd_en, sprite_addr, bg_color, bg_valid});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    prime();
  endtask

  task automatic test_single_pixel();
    logic ev; logic [8:0] ec;
    map_mem[5] = 6'd7;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) step(1'b1, 3, 2, 5, ev, ec);
      else        step(1'b0, 0, 0, 0, ev, ec);
      if (i == 2) begin
        checks++;
        if (sprite_addr !== 12'd467 || sprite_rd_en !== 1'b1) begin
          failures++;
          $display("FAIL single_sprite_addr got=%0d/%b want=467/1", sprite_addr, sprite_rd_en);
        end
      end
      if (i == 4) begin
        checks++;
        if (bg_valid !== 1'b1 || bg_color !== sprite_mem[467]) begin
          failures++;
          $display("FAIL single_color got=%b/%h want=1/%h", bg_valid, bg_color, sprite_mem[467]);
        end
      end
      checks++;
      if (bg_valid !== ev || bg_color !== ec) begin
        failures++;
        $display("FAIL single_cycle%0d got=%b/%h want=%b/%h", i, bg_valid, bg_color, ev, ec);
      end
    end
  endtask

  task automatic test_tile_boundary();
    logic ev; logic [8:0] ec;
    map_mem[0] = 6'd63;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) step(1'b1, 7, 7, 0, ev, ec);
      else        step(1'b0, 0, 0, 0, ev, ec);
      if (i == 2) begin
        checks++;
        if (sprite_addr !== 12'd4095) begin
          failures++;
          $display("FAIL tile_boundary_addr got=%0d want=4095", sprite_addr);
        end
      end
      checks++;
      if (bg_valid !== ev || bg_color !== ec) begin
        failures++;
        $display("FAIL tile_boundary_cycle%0d got=%b/%h want=%b/%h", i, bg_valid, bg_color, ev, ec);
      end
    end
  endtask

  task automatic test_line();
    logic ev; logic [8:0] ec;
    for (int i = 0; i < 646; i++) begin
      if (i < 640) step(1'b1, i, 0, blk(i, 0), ev, ec);
      else         step(1'b0, 0, 0, 0, ev, ec);
      checks++;
      if (bg_valid !== ev || bg_color !== ec) begin
        failures++;
        $display("FAIL line_x%0d got=%b/%h want=%b/%h", i - 4, bg_valid, bg_color, ev, ec);
      end
    end
  endtask

  task automatic test_blanking();
    logic ev; logic [8:0] ec;
    int m0, s0, nvalid, nblank_out;
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 0, ev, ec);
    m0 = map_pulses; s0 = spr_pulses; nvalid = 0; nblank_out = 0;
    for (int i = 0; i < 36; i++) begin
      if (i < 30 && (i < 10 || i >= 20)) begin
        step(1'b1, i * 8, 16, blk(i * 8, 16), ev, ec);
        nvalid++;
      end else begin
        step(1'b0, i * 8, 16, blk(i * 8, 16), ev, ec);
      end
      if (i >= 14 && i < 24 && bg_valid === 1'b0 && bg_color === 9'd0) nblank_out++;
      checks++;
      if (bg_valid !== ev || bg_color !== ec) begin
        failures++;
        $display("FAIL blank_cycle%0d got=%b/%h want=%b/%h", i, bg_valid, bg_color, ev, ec);
      end
    end
    checks++;
    if (nblank_out !== 10) begin
      failures++;
      $display("FAIL blank_window got=%0d want=10", nblank_out);
    end
    checks++;
    if (map_pulses - m0 !== nvalid || spr_pulses - s0 !== nvalid) begin
      failures++;
      $display("FAIL blank_strobes got=%0d/%0d want=%0d/%0d",
               map_pulses - m0, spr_pulses - s0, nvalid, nvalid);
    end
  endtask

  task automatic test_block_run();
    logic ev; logic [8:0] ec;
    int m0, s0, want_map;
`ifdef BG_TILE_REUSE_EN
    want_map = 1;
`else
    want_map = 8;
`endif
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 0, ev, ec);
    m0 = map_pulses; s0 = spr_pulses;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) step(1'b1, 16 + i, 9, blk(16, 9), ev, ec);
      else       step(1'b0, 0, 0, 0, ev, ec);
      checks++;
      if (bg_valid !== ev || bg_color !== ec) begin
        failures++;
        $display("FAIL block_run_cycle%0d got=%b/%h want=%b/%h", i, bg_valid, bg_color, ev, ec);
      end
    end
    checks++;
    if (map_pulses - m0 !== want_map || spr_pulses - s0 !== 8) begin
      failures++;
      $display("FAIL block_run_strobes got=%0d/%0d want=%0d/8",
               map_pulses - m0, spr_pulses - s0, want_map);
    end
  endtask

  task automatic test_back_to_back();
    logic ev; logic [8:0] ec;
    int x, y;
    for (int i = 0; i < 306; i++) begin
      x = $urandom_range(639);
      y = $urandom_range(479);
      if (i < 300) step(1'($urandom_range(3) != 0), x, y, blk(x, y), ev, ec);
      else         step(1'b0, 0, 0, 0, ev, ec);
      checks++;
      if (bg_valid !== ev || bg_color !== ec) begin
        failures++;
        $display("FAIL random_cycle%0d got=%b/%h want=%b/%h", i, bg_valid, bg_color, ev, ec);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic ev; logic [8:0] ec;
    int first;
    for (int i = 0; i < 6; i++) step(1'b1, 40 + i, 24, blk(40 + i, 24), ev, ec);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({map_rd_en, map_addr, sprite_rd_en, sprite_addr, bg_color, bg_valid} !== 37'd0) begin
      failures++;
      $display("FAIL midstream_reset_outputs got=%h want=0",
               {map_rd_en, map_addr, sprite_rd_en, sprite_addr, bg_color, bg_valid});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    prime();
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 100 + i, 33, blk(100 + i, 33), ev, ec);
      if (first < 0 && bg_valid === 1'b1) first = i;
      checks++;
      if (bg_valid !== ev || bg_color !== ec) begin
        failures++;
        $display("FAIL after_reset_cycle%0d got=%b/%h want=%b/%h", i, bg_valid, bg_color, ev, ec);
      end
    end
    checks++;
    if (first !== 5) begin
      failures++;
      $display("FAIL after_reset_first_valid got=%0d want=5", first);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) map_mem[i] = 6'($urandom);
    for (int i = 0; i < 4096; i++) sprite_mem[i] = 9'($urandom);
    test_reset();
    test_single_pixel();
    test_tile_boundary();
    test_line();
    test_blanking();
    test_block_run();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
